// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier with a start/busy/done handshake.
// It runs WIDTH+1 steps on operands extended by one bit, so signed and unsigned products are both exact.
module booth_mul_seq #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     src1,
  input  logic [WIDTH-1:0]     src2,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   calc_res
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

  state_t             state_q;
  logic [WIDTH+1:0]   m_q;
  logic [WIDTH+1:0]   a_q;
  logic [WIDTH:0]     q_q;
  logic               q1_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic               done_q;
  logic [2*WIDTH-1:0] res_q;

  logic [WIDTH+1:0]   a_sum;
  logic [WIDTH+1:0]   a_d;
  logic [WIDTH:0]     q_d;
  logic               q1_d;
  logic               s1_ext;
  logic               s2_ext;

  assign s1_ext = is_signed & src1[WIDTH-1];
  assign s2_ext = is_signed & src2[WIDTH-1];

  // One Booth step: add/subtract M, then shift {A,Q,q_1} arithmetically right by one.
  always_comb begin
    a_sum = a_q;
    case ({q_q[0], q1_q})
      2'b10:   a_sum = a_q - m_q;
      2'b01:   a_sum = a_q + m_q;
      default: a_sum = a_q;
    endcase
    a_d  = {a_sum[WIDTH+1], a_sum[WIDTH+1:1]};
    q_d  = {a_sum[0], q_q[WIDTH:1]};
    q1_d = q_q[0];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            m_q     <= {{2{s1_ext}}, src1};
            q_q     <= {s2_ext, src2};
            a_q     <= '0;
            q1_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          a_q   <= a_d;
          q_q   <= q_d;
          q1_q  <= q1_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            // Low 2*WIDTH bits of the post-step {A,Q} are the exact product.
            res_q   <= {a_d[WIDTH-2:0], q_d};
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign calc_res = res_q;

endmodule
